// File: rtl/proj_pkg.sv
// proj_pkg: shared constants and types for the FM index generator blocks.
//   FM_IDX_W / FM_NUM_CH / FM_LAP_W / FM_DEF_LIMIT: default widths, channel count
//   and post-reset wrap limit.
//   fm_idx_t, fm_lap_t: default-width index and lap types.
//   fm_dir_e: step direction (FM_UP counts toward the limit, FM_DOWN toward 0).
package proj_pkg;

  localparam int unsigned FM_IDX_W     = 8;
  localparam int unsigned FM_NUM_CH    = 4;
  localparam int unsigned FM_LAP_W     = 8;
  localparam int unsigned FM_DEF_LIMIT = 7;

  typedef logic [FM_IDX_W-1:0] fm_idx_t;
  typedef logic [FM_LAP_W-1:0] fm_lap_t;

  typedef enum logic {
    FM_UP   = 1'b0,
    FM_DOWN = 1'b1
  } fm_dir_e;

endpackage

// File: rtl/proj_fm_chan_counter.sv
// proj_fm_chan_counter: one ring-buffer index channel.
//   in_clk, in_rst    : clock, asynchronous active-high reset
//   in_cfg_we         : load in_cfg_limit as the new limit, restart index and lap
//   in_cfg_limit      : top index value; the channel counts 0..limit
//   in_clr            : synchronous clear of index and lap (limit kept)
//   in_en, in_dir     : step enable and direction (0 up, 1 down)
//   out_index         : registered index
//   out_wrap          : one-cycle pulse in the cycle the post-wrap index is shown
//   out_lap           : saturating count of wraps
module proj_fm_chan_counter
  import proj_pkg::*;
#(
  parameter int unsigned IDX_W     = FM_IDX_W,
  parameter int unsigned LAP_W     = FM_LAP_W,
  parameter int unsigned DEF_LIMIT = FM_DEF_LIMIT
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_cfg_we,
  input  logic [IDX_W-1:0] in_cfg_limit,
  input  logic             in_clr,
  input  logic             in_en,
  input  logic             in_dir,
  output logic [IDX_W-1:0] out_index,
  output logic             out_wrap,
  output logic [LAP_W-1:0] out_lap
);

  logic [IDX_W-1:0] r_limit, w_limit_d;
  logic [IDX_W-1:0] r_index, w_index_d;
  logic [LAP_W-1:0] r_lap, w_lap_d;
  logic             r_wrap, w_wrap_d;
  fm_dir_e          w_dir;

  assign w_dir = fm_dir_e'(in_dir);

  // Priority: config write > clear > step; otherwise hold.
  always_comb begin
    w_limit_d = r_limit;
    w_index_d = r_index;
    w_lap_d   = r_lap;
    w_wrap_d  = 1'b0;
    if (in_cfg_we) begin
      w_limit_d = in_cfg_limit;
      w_index_d = '0;
      w_lap_d   = '0;
    end else if (in_clr) begin
      w_index_d = '0;
      w_lap_d   = '0;
    end else if (in_en) begin
      if (w_dir == FM_DOWN) begin
        if (r_index == '0) begin
          w_index_d = r_limit;
          w_wrap_d  = 1'b1;
        end else begin
          w_index_d = r_index - IDX_W'(1);
        end
      end else begin
        // >= rather than == so a stray out-of-range index still wraps to 0.
        if (r_index >= r_limit) begin
          w_index_d = '0;
          w_wrap_d  = 1'b1;
        end else begin
          w_index_d = r_index + IDX_W'(1);
        end
      end
      if (w_wrap_d && (r_lap != '1)) begin
        w_lap_d = r_lap + LAP_W'(1);
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_limit <= IDX_W'(DEF_LIMIT);
      r_index <= '0;
      r_lap   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_limit <= w_limit_d;
      r_index <= w_index_d;
      r_lap   <= w_lap_d;
      r_wrap  <= w_wrap_d;
    end
  end

  assign out_index = r_index;
  assign out_wrap  = r_wrap;
  assign out_lap   = r_lap;

endmodule

// File: rtl/proj_fm_multi_index_gen.sv
// proj_fm_multi_index_gen: NUM_CH independent ring-buffer index channels.
//   in_clk, in_rst          : clock, asynchronous active-high reset
//   in_cfg_valid/ch/limit   : limit write to one channel
//   in_en, in_dir, in_clr   : per-channel step enable, direction, clear
//   out_index               : packed indices, channel c at [c*IDX_W +: IDX_W]
//   out_wrap                : per-channel one-cycle wrap pulse
//   out_lap                 : packed saturating lap counts
//   out_cfg_err             : one-cycle pulse on a write to a nonexistent channel
module proj_fm_multi_index_gen
  import proj_pkg::*;
#(
  parameter int unsigned IDX_W     = FM_IDX_W,
  parameter int unsigned NUM_CH    = FM_NUM_CH,
  parameter int unsigned LAP_W     = FM_LAP_W,
  parameter int unsigned DEF_LIMIT = FM_DEF_LIMIT,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_cfg_valid,
  input  logic [CH_W-1:0]         in_cfg_ch,
  input  logic [IDX_W-1:0]        in_cfg_limit,
  input  logic [NUM_CH-1:0]       in_en,
  input  logic [NUM_CH-1:0]       in_dir,
  input  logic [NUM_CH-1:0]       in_clr,
  output logic [NUM_CH*IDX_W-1:0] out_index,
  output logic [NUM_CH-1:0]       out_wrap,
  output logic [NUM_CH*LAP_W-1:0] out_lap,
  output logic                    out_cfg_err
);

  // One extra bit so NUM_CH itself is representable for the range compare.
  localparam logic [CH_W:0] NumChW = (CH_W + 1)'(NUM_CH);

  logic w_cfg_bad;
  logic r_cfg_err;

  assign w_cfg_bad = in_cfg_valid && ({1'b0, in_cfg_ch} >= NumChW);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
    end
  end

  assign out_cfg_err = r_cfg_err;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_cfg_we;
    assign w_cfg_we = in_cfg_valid && (in_cfg_ch == CH_W'(c));

    proj_fm_chan_counter #(
      .IDX_W     (IDX_W),
      .LAP_W     (LAP_W),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_chan (
      .in_clk       (in_clk),
      .in_rst       (in_rst),
      .in_cfg_we    (w_cfg_we),
      .in_cfg_limit (in_cfg_limit),
      .in_clr       (in_clr[c]),
      .in_en        (in_en[c]),
      .in_dir       (in_dir[c]),
      .out_index    (out_index[c*IDX_W +: IDX_W]),
      .out_wrap     (out_wrap[c]),
      .out_lap      (out_lap[c*LAP_W +: LAP_W])
    );
  end

endmodule
